readout_byte_sequencer: RTL and testbench
=========================================

// Module: readout_byte_sequencer
// PURPOSE
//  Produces the raw_serial_out byte stream consumed by the serial output mux during readout.
//  Buffers digitizer bytes in a FIFO and frames them as HEADER, COUNT, DATA[0..COUNT-1], TRAILER.
//  Advances one byte per completed SPI byte slot, as indicated by the SPI load_cnt_ser counter.
// PARAMETERS
//  DEPTH     16     FIFO depth in bytes; power of 2, >= 2
//  AW        $clog2(DEPTH)  FIFO pointer width; derived, do not override
//  HEADER    8'hA5  first byte of every frame
//  TRAILER   8'h5A  last byte of every frame
//  LAST_CNT  8'd7   load_cnt_ser value that marks the final bit of a byte slot
// PORTS
//  sclk           in   1     SPI clock; the only clock
//  rst            in   1     synchronous, active-high reset
//  readout_en     in   1     level; high while a readout instruction is active
//  wr_valid       in   1     write request from digitizer side
//  wr_data        in   8     byte to buffer
//  wr_ready       out  1     high when FIFO not full
//  load_cnt_ser   in   8     bit-slot counter from SPI
//  raw_serial_out out  8     byte presented to the serial output mux (registered)
//  frame_active   out  1     high in HDR/CNT/DATA/TRL
//  frame_done     out  1     one-cycle pulse on TRL->IDLE
//  fifo_count     out  AW+1  current FIFO occupancy, 0..DEPTH
// BEHAVIOUR
//  Reset: state=IDLE; FIFO empty; raw_serial_out=8'h00; frame_active=0; frame_done=0; wr_ready=1; fifo_count=0.
//  byte_done = (load_cnt_ser==LAST_CNT) && (prev_cnt!=LAST_CNT); prev_cnt is a register with reset value 8'h00.
//   A counter held at LAST_CNT produces exactly one byte_done.
//  Start: start = readout_en && !readout_en_q, where readout_en_q is readout_en registered.
//  FSM, all transitions on sclk:
//   IDLE: raw_serial_out=8'h00. On start -> HDR.
//   HDR:  raw_serial_out=HEADER. On byte_done -> CNT; latch frame_len = min(fifo_count,255).
//   CNT:  raw_serial_out=frame_len[7:0]. On byte_done: -> DATA if frame_len!=0, else -> TRL.
//   DATA: raw_serial_out=FIFO head. On byte_done: pop one byte; sent++.
//         When sent reaches frame_len -> TRL; otherwise stay in DATA.
//   TRL:  raw_serial_out=TRAILER. On byte_done -> IDLE, and frame_done=1 for one cycle.
//  Output latency: raw_serial_out settles on the cycle after the state change or pop,
//   i.e. 2 sclk after load_cnt_ser first reaches LAST_CNT.
//  FIFO write: a write occurs when wr_valid && wr_ready, in any state.
//   A write while full is ignored and the data is discarded.
//  Push and pop in the same cycle: both take effect; fifo_count is unchanged.
//  A pop when full raises wr_ready on the next cycle.
//  Bytes written after frame_len is latched are not part of the current frame.
//   They remain in the FIFO for the next frame.
//  Abort: readout_en low while in any non-IDLE state -> IDLE on the next cycle.
//   No frame_done pulse. Unsent FIFO bytes are retained. sent and frame_len are cleared.
//  Start asserted while not in IDLE: ignored.
//  Pointers wrap modulo DEPTH. fifo_count is the exact occupancy, DEPTH when full.
//  rst mid-frame: all state, pointers and outputs return to their reset values in the next cycle.
// TESTING
//  Write 3 bytes 11,22,33; pulse readout_en; drive 6 byte slots.
//   -> raw_serial_out = A5,03,11,22,33,5A; frame_done once; FIFO empty.
//  Empty FIFO, start readout, 3 byte slots -> A5,00,5A; DATA state never entered.
//  Fill 16 bytes -> wr_ready=0; a 17th write is dropped; fifo_count stays 16.
//   Read the frame -> COUNT byte = 10, 16 data bytes in order.
//  Write 2 bytes; after CNT latches 02, push 44 during DATA.
//   -> frame carries 2 data bytes; 44 remains; fifo_count=1 after frame_done.
//  Drop readout_en in DATA after 1 of 4 bytes -> IDLE, no frame_done, fifo_count=3.
//   Next readout sends COUNT=03.
//  Hold load_cnt_ser=7 for 5 cycles -> single advance.
//   Assert rst mid-DATA -> raw_serial_out=00, fifo_count=0.

Source files
------------

// File: rtl/readout_byte_sequencer.sv
// readout_byte_sequencer: frames buffered digitizer bytes as HEADER, COUNT, DATA..., TRAILER,
// advancing one byte per completed SPI byte slot.
//   sclk           - SPI clock, the only clock
//   rst            - synchronous active-high reset
//   readout_en     - level, high while a readout is active; rising edge starts a frame
//   wr_valid       - write request from the digitizer side
//   wr_data        - byte to buffer
//   wr_ready       - high when the FIFO is not full
//   load_cnt_ser   - bit-slot counter from SPI; LAST_CNT marks the last bit of a byte
//   raw_serial_out - registered byte presented to the serial output mux
//   frame_active   - registered, high while in HDR/CNT/DATA/TRL
//   frame_done     - one-cycle pulse when TRL completes
//   fifo_count     - FIFO occupancy, 0..DEPTH
module readout_byte_sequencer #(
    parameter int         DEPTH    = 16,
    parameter int         AW       = $clog2(DEPTH),
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter logic [7:0] TRAILER  = 8'h5A,
    parameter logic [7:0] LAST_CNT = 8'd7
) (
    input  logic        sclk,
    input  logic        rst,
    input  logic        readout_en,
    input  logic        wr_valid,
    input  logic [7:0]  wr_data,
    output logic        wr_ready,
    input  logic [7:0]  load_cnt_ser,
    output logic [7:0]  raw_serial_out,
    output logic        frame_active,
    output logic        frame_done,
    output logic [AW:0] fifo_count
);
    typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, TRL} state_t;
    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [7:0]    prev_cnt, frame_len, sent, len_sat;
    logic          readout_en_q, byte_done, start, abort, push, pop;

    // Edge-detect the counter so a counter parked at LAST_CNT advances only once
    assign byte_done = (load_cnt_ser == LAST_CNT) && (prev_cnt != LAST_CNT);
    assign start     = readout_en && !readout_en_q;
    assign abort     = !readout_en && (state != IDLE);
    assign wr_ready  = fifo_count != (AW+1)'(DEPTH);
    assign push      = wr_valid && wr_ready;
    assign pop       = (state == DATA) && byte_done && !abort;
    assign len_sat   = 32'(fifo_count) > 32'd255 ? 8'hFF : 8'(fifo_count);

    always_ff @(posedge sclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fifo_count     <= '0;
            prev_cnt       <= 8'h00;
            readout_en_q   <= 1'b0;
            frame_len      <= 8'h00;
            sent           <= 8'h00;
            raw_serial_out <= 8'h00;
            frame_active   <= 1'b0;
            frame_done     <= 1'b0;
        end else begin
            prev_cnt     <= load_cnt_ser;
            readout_en_q <= readout_en;
            frame_done   <= 1'b0;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count   <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            // Outputs follow the state one cycle late, so a pop shows its new head next cycle
            frame_active   <= state != IDLE;
            raw_serial_out <= state == HDR  ? HEADER :
                              state == CNT  ? frame_len :
                              state == DATA ? mem[rd_ptr] :
                              state == TRL  ? TRAILER : 8'h00;
            if (abort) begin
                state     <= IDLE;
                sent      <= 8'h00;
                frame_len <= 8'h00;
            end else begin
                case (state)
                    IDLE: if (start) state <= HDR;
                    HDR: if (byte_done) begin
                        state     <= CNT;
                        frame_len <= len_sat;
                    end
                    CNT: if (byte_done) state <= frame_len != 8'h00 ? DATA : TRL;
                    DATA: if (byte_done) begin
                        sent <= sent + 8'd1;
                        if (sent + 8'd1 == frame_len) begin
                            state <= TRL;
                            sent  <= 8'h00;
                        end
                    end
                    TRL: if (byte_done) begin
                        state      <= IDLE;
                        frame_done <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_readout_byte_sequencer.sv
// tb_readout_byte_sequencer: directed self-checking bench for readout_byte_sequencer.
module tb_readout_byte_sequencer;
    logic       sclk = 1'b0;
    logic       rst = 1'b1;
    logic       readout_en = 1'b0;
    logic       wr_valid = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_ready;
    logic [7:0] load_cnt_ser = 8'h00;
    logic [7:0] raw_serial_out;
    logic       frame_active;
    logic       frame_done;
    logic [4:0] fifo_count;
    int         checks = 0;
    int         errors = 0;
    int         done_cnt = 0;

    readout_byte_sequencer dut (
        .sclk(sclk), .rst(rst), .readout_en(readout_en), .wr_valid(wr_valid),
        .wr_data(wr_data), .wr_ready(wr_ready), .load_cnt_ser(load_cnt_ser),
        .raw_serial_out(raw_serial_out), .frame_active(frame_active),
        .frame_done(frame_done), .fifo_count(fifo_count)
    );

    always #5 sclk = ~sclk;

    always @(negedge sclk) if (frame_done) done_cnt++;

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    // One byte slot: counter reaches LAST_CNT for a cycle, output settles one cycle later
    task automatic slot();
        load_cnt_ser = 8'd7;
        tick();
        load_cnt_ser = 8'd0;
        tick();
    endtask

    task automatic start_readout();
        readout_en = 1'b1;
        tick();
        tick();
    endtask

    task automatic stop_readout();
        readout_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (raw_serial_out !== 8'h00) begin errors++; $display("FAIL reset_raw got %h exp 00", raw_serial_out); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL reset_active got %b exp 0", frame_active); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", frame_done); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [7:0] exp [6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h5A};
        int d0 = done_cnt;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL basic_count_in got %0d exp 3", fifo_count); end
        start_readout();
        checks++; if (frame_active !== 1'b1) begin errors++; $display("FAIL basic_active got %b exp 1", frame_active); end
        for (int i = 0; i < 6; i++) begin
            checks++; if (raw_serial_out !== exp[i]) begin errors++; $display("FAIL basic_byte%0d got %h exp %h", i, raw_serial_out, exp[i]); end
            slot();
        end
        checks++; if (raw_serial_out !== 8'h00) begin errors++; $display("FAIL basic_idle_raw got %h exp 00", raw_serial_out); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", done_cnt - d0); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL basic_count_out got %0d exp 0", fifo_count); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL basic_inactive got %b exp 0", frame_active); end
        stop_readout();
    endtask

    task automatic test_empty_frame();
        logic [7:0] exp [3] = '{8'hA5, 8'h00, 8'h5A};
        int d0 = done_cnt;
        start_readout();
        for (int i = 0; i < 3; i++) begin
            checks++; if (raw_serial_out !== exp[i]) begin errors++; $display("FAIL empty_byte%0d got %h exp %h", i, raw_serial_out, exp[i]); end
            slot();
        end
        checks++; if (raw_serial_out !== 8'h00) begin errors++; $display("FAIL empty_idle_raw got %h exp 00", raw_serial_out); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL empty_done got %0d exp 1", done_cnt - d0); end
        stop_readout();
    endtask

    task automatic test_full_fifo();
        for (int i = 0; i < 16; i++) write_byte(8'h80 + 8'(i));
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL full_wr_ready got %b exp 0", wr_ready); end
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", fifo_count); end
        write_byte(8'hEE);
        checks++; if (fifo_count !== 5'd16) begin errors++; $display("FAIL full_drop_count got %0d exp 16", fifo_count); end
        start_readout();
        checks++; if (raw_serial_out !== 8'hA5) begin errors++; $display("FAIL full_hdr got %h exp a5", raw_serial_out); end
        slot();
        checks++; if (raw_serial_out !== 8'h10) begin errors++; $display("FAIL full_cnt got %h exp 10", raw_serial_out); end
        slot();
        for (int i = 0; i < 16; i++) begin
            checks++; if (raw_serial_out !== 8'h80 + 8'(i)) begin errors++; $display("FAIL full_data%0d got %h exp %h", i, raw_serial_out, 8'h80 + 8'(i)); end
            slot();
            if (i == 0) begin
                checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL full_ready_after_pop got %b exp 1", wr_ready); end
            end
        end
        checks++; if (raw_serial_out !== 8'h5A) begin errors++; $display("FAIL full_trl got %h exp 5a", raw_serial_out); end
        slot();
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL full_count_out got %0d exp 0", fifo_count); end
        stop_readout();
    endtask

    task automatic test_late_write();
        logic [7:0] exp1 [3] = '{8'h01, 8'h02, 8'h5A};
        logic [7:0] exp2 [4] = '{8'hA5, 8'h01, 8'h44, 8'h5A};
        int d0 = done_cnt;
        write_byte(8'h01);
        write_byte(8'h02);
        start_readout();
        checks++; if (raw_serial_out !== 8'hA5) begin errors++; $display("FAIL late_hdr got %h exp a5", raw_serial_out); end
        slot();
        checks++; if (raw_serial_out !== 8'h02) begin errors++; $display("FAIL late_cnt got %h exp 02", raw_serial_out); end
        slot();
        write_byte(8'h44);
        for (int i = 0; i < 3; i++) begin
            checks++; if (raw_serial_out !== exp1[i]) begin errors++; $display("FAIL late_byte%0d got %h exp %h", i, raw_serial_out, exp1[i]); end
            slot();
        end
        checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL late_left got %0d exp 1", fifo_count); end
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL late_done got %0d exp 1", done_cnt - d0); end
        stop_readout();
        start_readout();
        for (int i = 0; i < 4; i++) begin
            checks++; if (raw_serial_out !== exp2[i]) begin errors++; $display("FAIL late2_byte%0d got %h exp %h", i, raw_serial_out, exp2[i]); end
            slot();
        end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL late2_count got %0d exp 0", fifo_count); end
        stop_readout();
    endtask

    task automatic test_abort();
        logic [7:0] exp [6] = '{8'hA5, 8'h03, 8'hB1, 8'hB2, 8'hB3, 8'h5A};
        int d0 = done_cnt;
        for (int i = 0; i < 4; i++) write_byte(8'hB0 + 8'(i));
        start_readout();
        slot();
        slot();
        checks++; if (raw_serial_out !== 8'hB0) begin errors++; $display("FAIL abort_first got %h exp b0", raw_serial_out); end
        slot();
        stop_readout();
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL abort_active got %b exp 0", frame_active); end
        checks++; if (raw_serial_out !== 8'h00) begin errors++; $display("FAIL abort_raw got %h exp 00", raw_serial_out); end
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL abort_count got %0d exp 3", fifo_count); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_done got %0d exp 0", done_cnt - d0); end
        start_readout();
        for (int i = 0; i < 6; i++) begin
            checks++; if (raw_serial_out !== exp[i]) begin errors++; $display("FAIL abort2_byte%0d got %h exp %h", i, raw_serial_out, exp[i]); end
            slot();
        end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL abort2_count got %0d exp 0", fifo_count); end
        stop_readout();
    endtask

    task automatic test_hold_and_reset();
        write_byte(8'hC1);
        write_byte(8'hC2);
        start_readout();
        load_cnt_ser = 8'd7;
        repeat (5) tick();
        load_cnt_ser = 8'd0;
        tick();
        checks++; if (raw_serial_out !== 8'h02) begin errors++; $display("FAIL hold_cnt got %h exp 02", raw_serial_out); end
        slot();
        checks++; if (raw_serial_out !== 8'hC1) begin errors++; $display("FAIL hold_data got %h exp c1", raw_serial_out); end
        rst = 1'b1;
        readout_en = 1'b0;
        tick();
        rst = 1'b0;
        checks++; if (raw_serial_out !== 8'h00) begin errors++; $display("FAIL rst_raw got %h exp 00", raw_serial_out); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", fifo_count); end
        checks++; if (frame_active !== 1'b0) begin errors++; $display("FAIL rst_active got %b exp 0", frame_active); end
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL rst_wr_ready got %b exp 1", wr_ready); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_empty_frame();
        test_full_fifo();
        test_late_write();
        test_abort();
        test_hold_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
